// File: rtl/div_const.sv
// Sequential signed fixed-point divider: outp = inp / const_in, one quotient bit per cycle.
// Restoring division on magnitudes, then sign fix, truncation toward zero and saturation.
module div_const #(
  parameter int CONSTS_WHOLE = 8,
  parameter int CONSTS_FRAC  = 40,
  parameter int IN_WHOLE     = 20,
  parameter int IN_FRAC      = 40,
  parameter int OUT_WHOLE    = 20,
  parameter int OUT_FRAC     = 40
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_WHOLE+IN_FRAC-1:0]      inp,
  input  logic [CONSTS_WHOLE+CONSTS_FRAC-1:0] const_in,
  input  logic                             arm,
  output logic [OUT_WHOLE+OUT_FRAC-1:0]    outp,
  output logic                             finished,
  output logic                             div_zero,
  output logic                             overflow
);
  localparam int IW   = IN_WHOLE + IN_FRAC;
  localparam int CW   = CONSTS_WHOLE + CONSTS_FRAC;
  localparam int OW   = OUT_WHOLE + OUT_FRAC;
  localparam int SH   = CONSTS_FRAC + OUT_FRAC - IN_FRAC;
  localparam int Q    = IW + SH;
  localparam int CNTW = $clog2(Q + 1);
  localparam int W    = ((Q > OW) ? Q : OW) + 1;

  if (CONSTS_FRAC + OUT_FRAC < IN_FRAC) begin : g_bad_frac
    $error("div_const: CONSTS_FRAC+OUT_FRAC must be >= IN_FRAC");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [Q-1:0]    dvd_q, dvd_d;
  logic [Q-1:0]    quot_q, quot_d;
  logic [CW-1:0]   dsr_q, dsr_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            dz_q, dz_d;
  logic [OW-1:0]   outp_q, outp_d;
  logic            fin_q, fin_d;
  logic            dzf_q, dzf_d;
  logic            ovf_q, ovf_d;

  logic [IW-1:0]   in_mag;
  logic [CW-1:0]   c_mag;
  logic [CW:0]     trial, diff;
  logic            ge;
  logic [W-1:0]    mag_ext, pos_max, neg_lim, neg_val;
  logic [OW-1:0]   max_out, min_out, fix_out;
  logic            fix_ovf;

  // Magnitudes are unsigned at full width, so the most-negative input is exact.
  assign in_mag  = inp[IW-1] ? IW'(-inp) : inp;
  assign c_mag   = const_in[CW-1] ? CW'(-const_in) : const_in;

  assign trial   = {rem_q, dvd_q[Q-1]};
  assign ge      = (trial >= {1'b0, dsr_q});
  assign diff    = trial - {1'b0, dsr_q};

  assign max_out = {1'b0, {(OW-1){1'b1}}};
  assign min_out = {1'b1, {(OW-1){1'b0}}};
  assign mag_ext = W'(quot_q);
  assign pos_max = W'(max_out);
  assign neg_lim = pos_max + W'(1);
  assign neg_val = -mag_ext;

  always_comb begin
    fix_out = '0;
    fix_ovf = 1'b0;
    if (dz_q) begin
      if (dvd_q == '0) begin
        fix_out = '0;
      end else begin
        fix_out = neg_q ? min_out : max_out;
        fix_ovf = 1'b1;
      end
    end else if (neg_q) begin
      if (mag_ext > neg_lim) begin
        fix_out = min_out;
        fix_ovf = 1'b1;
      end else begin
        fix_out = neg_val[OW-1:0];
      end
    end else begin
      if (mag_ext > pos_max) begin
        fix_out = max_out;
        fix_ovf = 1'b1;
      end else begin
        fix_out = mag_ext[OW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quot_d  = quot_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    outp_d  = outp_q;
    dzf_d   = dzf_q;
    ovf_d   = ovf_q;
    fin_d   = (state_q == DONE) && arm;
    case (state_q)
      IDLE: begin
        if (arm) begin
          dvd_d   = Q'(in_mag) << SH;
          dsr_d   = c_mag;
          neg_d   = inp[IW-1] ^ const_in[CW-1];
          dz_d    = (const_in == '0);
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = CNTW'(Q - 1);
          state_d = (const_in == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (!arm) begin
          state_d = IDLE;
        end else begin
          dvd_d  = dvd_q << 1;
          rem_d  = ge ? diff[CW-1:0] : trial[CW-1:0];
          quot_d = (quot_q << 1) | Q'(ge);
          cnt_d  = cnt_q - CNTW'(1);
          if (cnt_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        if (!arm) begin
          state_d = IDLE;
        end else begin
          outp_d  = fix_out;
          dzf_d   = dz_q;
          ovf_d   = fix_ovf;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!arm) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      quot_q  <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      outp_q  <= '0;
      fin_q   <= 1'b0;
      dzf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quot_q  <= quot_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      outp_q  <= outp_d;
      fin_q   <= fin_d;
      dzf_q   <= dzf_d;
      ovf_q   <= ovf_d;
    end
  end

  assign outp     = outp_q;
  assign finished = fin_q;
  assign div_zero = dzf_q;
  assign overflow = ovf_q;
endmodule
